decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: combinational RV32 decoder feeding a DEPTH-entry output FIFO.
// Define DECODE_STAGE_RV32M_EN to decode the RV32M multiply/divide group.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [5:0]      alu_op,
   output logic [3:0]      branch,
   output logic [8:0]      instr_type,
   output logic            alusrc,
   output logic            memtoreg,
   output logic            reg_en,
   output logic            mem_we,
   output logic [2:0]      mem_size,
   output logic            illegal,
   output logic [39:0]     char_out
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [5:0]      alu_op;
      logic [3:0]      branch;
      logic [8:0]      itype;
      logic            alusrc;
      logic            memtoreg;
      logic            reg_en;
      logic            mem_we;
      logic [2:0]      mem_size;
      logic            illegal;
      logic [39:0]     mnem;
   } entry_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   entry_t      dec;
   logic        bad;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Decode the offered word; illegal and all-zero words are normalised afterwards.
   always_comb begin
      dec = '0;
      bad = 1'b0;
      case (opcode)
         7'b0110011: begin
            dec.itype  = 9'b1_0000_0000;
            dec.reg_en = 1'b1;
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.rd     = instr[11:7];
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'd0:    {dec.alu_op, dec.mnem} = {6'd0, "ADD  "};
                  3'd1:    {dec.alu_op, dec.mnem} = {6'd5, "SLL  "};
                  3'd2:    {dec.alu_op, dec.mnem} = {6'd8, "SLT  "};
                  3'd3:    {dec.alu_op, dec.mnem} = {6'd9, "SLTU "};
                  3'd4:    {dec.alu_op, dec.mnem} = {6'd2, "XOR  "};
                  3'd5:    {dec.alu_op, dec.mnem} = {6'd6, "SRL  "};
                  3'd6:    {dec.alu_op, dec.mnem} = {6'd3, "OR   "};
                  default: {dec.alu_op, dec.mnem} = {6'd4, "AND  "};
               endcase
            end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
               {dec.alu_op, dec.mnem} = {6'd1, "SUB  "};
            end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
               {dec.alu_op, dec.mnem} = {6'd7, "SRA  "};
            end else if (funct7 == 7'h01) begin
`ifdef DECODE_STAGE_RV32M_EN
               dec.alu_op = 6'd20 + {3'b000, funct3};
               case (funct3)
                  3'd0:    dec.mnem = "MUL  ";
                  3'd1:    dec.mnem = "MULH ";
                  3'd2:    dec.mnem = "MULHS";
                  3'd3:    dec.mnem = "MULHU";
                  3'd4:    dec.mnem = "DIV  ";
                  3'd5:    dec.mnem = "DIVU ";
                  3'd6:    dec.mnem = "REM  ";
                  default: dec.mnem = "REMU ";
               endcase
`else
               bad = 1'b1;
`endif
            end else begin
               bad = 1'b1;
            end
         end
         7'b0010011: begin
            dec.itype  = 9'b0_1000_0000;
            dec.reg_en = 1'b1;
            dec.alusrc = 1'b1;
            dec.rs1    = instr[19:15];
            dec.rd     = instr[11:7];
            dec.imm    = sext(imm_i);
            case (funct3)
               3'd0: {dec.alu_op, dec.mnem} = {6'd10, "ADDI "};
               3'd1: begin
                  {dec.alu_op, dec.mnem} = {6'd14, "SLLI "};
                  bad = (funct7 != 7'h00);
               end
               3'd2: {dec.alu_op, dec.mnem} = {6'd17, "SLTI "};
               3'd3: {dec.alu_op, dec.mnem} = {6'd18, "SLTIU"};
               3'd4: {dec.alu_op, dec.mnem} = {6'd11, "XORI "};
               3'd5: begin
                  if (funct7 == 7'h00) {dec.alu_op, dec.mnem} = {6'd15, "SRLI "};
                  else if (funct7 == 7'h20) {dec.alu_op, dec.mnem} = {6'd16, "SRAI "};
                  else bad = 1'b1;
               end
               3'd6:    {dec.alu_op, dec.mnem} = {6'd12, "ORI  "};
               default: {dec.alu_op, dec.mnem} = {6'd13, "ANDI "};
            endcase
         end
         7'b0000011: begin
            dec.itype    = 9'b0_0100_0000;
            dec.alu_op   = 6'd10;
            dec.alusrc   = 1'b1;
            dec.memtoreg = 1'b1;
            dec.reg_en   = 1'b1;
            dec.mem_size = funct3;
            dec.rs1      = instr[19:15];
            dec.rd       = instr[11:7];
            dec.imm      = sext(imm_i);
            case (funct3)
               3'd0:    dec.mnem = "LB   ";
               3'd1:    dec.mnem = "LH   ";
               3'd2:    dec.mnem = "LW   ";
               3'd4:    dec.mnem = "LBU  ";
               3'd5:    dec.mnem = "LHU  ";
               default: bad = 1'b1;
            endcase
         end
         7'b0100011: begin
            dec.itype    = 9'b0_0010_0000;
            dec.alu_op   = 6'd10;
            dec.alusrc   = 1'b1;
            dec.mem_we   = 1'b1;
            dec.mem_size = funct3;
            dec.rs1      = instr[19:15];
            dec.rs2      = instr[24:20];
            dec.imm      = sext(imm_s);
            case (funct3)
               3'd0:    dec.mnem = "SB   ";
               3'd1:    dec.mnem = "SH   ";
               3'd2:    dec.mnem = "SW   ";
               default: bad = 1'b1;
            endcase
         end
         7'b1100011: begin
            dec.itype = 9'b0_0001_0000;
            dec.rs1   = instr[19:15];
            dec.rs2   = instr[24:20];
            dec.imm   = sext(imm_b);
            case (funct3)
               3'd0:    {dec.branch, dec.mnem} = {4'd1, "BEQ  "};
               3'd1:    {dec.branch, dec.mnem} = {4'd2, "BNE  "};
               3'd4:    {dec.branch, dec.mnem} = {4'd3, "BLT  "};
               3'd5:    {dec.branch, dec.mnem} = {4'd4, "BGE  "};
               3'd6:    {dec.branch, dec.mnem} = {4'd5, "BLTU "};
               3'd7:    {dec.branch, dec.mnem} = {4'd6, "BGEU "};
               default: bad = 1'b1;
            endcase
         end
         7'b1101111: begin
            dec.itype  = 9'b0_0000_1000;
            dec.branch = 4'd7;
            dec.reg_en = 1'b1;
            dec.rd     = instr[11:7];
            dec.imm    = sext(imm_j);
            dec.mnem   = "JAL  ";
         end
         7'b0110111: begin
            dec.itype  = 9'b0_0000_0100;
            dec.reg_en = 1'b1;
            dec.rd     = instr[11:7];
            dec.imm    = sext(imm_u);
            dec.mnem   = "LUI  ";
         end
         7'b0010111: begin
            dec.itype  = 9'b0_0000_0010;
            dec.alu_op = 6'd19;
            dec.alusrc = 1'b1;
            dec.reg_en = 1'b1;
            dec.rd     = instr[11:7];
            dec.imm    = sext(imm_u);
            dec.mnem   = "AUIPC";
         end
         7'b1100111: begin
            dec.itype  = 9'b0_0000_0001;
            dec.branch = 4'd8;
            dec.reg_en = 1'b1;
            dec.rs1    = instr[19:15];
            dec.rd     = instr[11:7];
            dec.imm    = sext(imm_i);
            dec.mnem   = "JALR ";
            bad        = (funct3 != 3'd0);
         end
         default: bad = 1'b1;
      endcase
      if (instr == 32'd0) begin
         dec      = '0;
         dec.mnem = "NOP  ";
      end else if (bad) begin
         dec         = '0;
         dec.illegal = 1'b1;
         dec.mnem    = "ILLGL";
      end
      dec.pc = pc;
   end

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push;
   logic          pop;

   // Reset gates both handshakes so nothing transfers in the reset cycle.
   assign full      = (count == CW'(DEPTH));
   assign in_ready  = !reset && !full;
   assign out_valid = !reset && (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && !flush && push) mem[wr_ptr] <= dec;
   end

   entry_t head;

   always_comb begin
      head      = '0;
      head.mnem = "XXXXX";
      if (count != '0) head = mem[rd_ptr];
   end

   assign out_pc     = head.pc;
   assign rs1        = head.rs1;
   assign rs2        = head.rs2;
   assign rd         = head.rd;
   assign imm        = head.imm;
   assign alu_op     = head.alu_op;
   assign branch     = head.branch;
   assign instr_type = head.itype;
   assign alusrc     = head.alusrc;
   assign memtoreg   = head.memtoreg;
   assign reg_en     = head.reg_en;
   assign mem_we     = head.mem_we;
   assign mem_size   = head.mem_size;
   assign illegal    = head.illegal;
   assign char_out   = head.mnem;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, hand-written queue/flush/reset sequences and a
// randomized run against a mnemonic-level reference model of decode_stage.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
`ifdef DECODE_STAGE_RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     instr = '0;
   logic [XLEN-1:0] pc = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm;
   logic [5:0]      alu_op;
   logic [3:0]      branch;
   logic [8:0]      instr_type;
   logic            alusrc, memtoreg, reg_en, mem_we;
   logic [2:0]      mem_size;
   logic            illegal;
   logic [39:0]     char_out;

   decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm(imm), .alu_op(alu_op), .branch(branch), .instr_type(instr_type),
      .alusrc(alusrc), .memtoreg(memtoreg), .reg_en(reg_en), .mem_we(mem_we),
      .mem_size(mem_size), .illegal(illegal), .char_out(char_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [5:0]  alu_op;
      logic [3:0]  branch;
      logic [8:0]  typ;
      logic        alusrc;
      logic        memtoreg;
      logic        reg_en;
      logic        mem_we;
      logic [2:0]  mem_size;
      logic        illegal;
      logic [39:0] ch;
   } exp_t;

   typedef struct {
      logic [31:0] ins;
      logic [39:0] ch;
      logic [5:0]  alu;
      logic [3:0]  br;
      logic [8:0]  typ;
      logic        ill;
      logic [31:0] imm;
      logic [4:0]  rd;
   } vec_t;

   string rNames[8]   = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
   string mNames[8]   = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};
   string iNames[8]   = '{"ADDI", "", "SLTI", "SLTIU", "XORI", "", "ORI", "ANDI"};
   string ldNames[8]  = '{"LB", "LH", "LW", "", "LBU", "LHU", "", ""};
   string stNames[8]  = '{"SB", "SH", "SW", "", "", "", "", ""};
   string brNames[8]  = '{"BEQ", "BNE", "", "", "BLT", "BGE", "BLTU", "BGEU"};
   string brCodes[9]  = '{"", "BEQ", "BNE", "BLT", "BGE", "BLTU", "BGEU", "JAL", "JALR"};
   string aluNames[28] = '{"ADD", "SUB", "XOR", "OR", "AND", "SLL", "SRL", "SRA", "SLT", "SLTU",
                           "ADDI", "XORI", "ORI", "ANDI", "SLLI", "SRLI", "SRAI", "SLTI", "SLTIU",
                           "AUIPC", "MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

   exp_t q[$];
   int   compared = 0;
   int   failed = 0;

   function automatic logic [39:0] toChars(input string s);
      logic [39:0] r;
      r = {5{8'h20}};
      for (int i = 0; i < 5 && i < s.len(); i++) r[39-8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic string mnemOf(input logic [31:0] w);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      if (w == 32'd0) return "NOP";
      case (w[6:0])
         7'h33: begin
            if (f7 == 7'h00) return rNames[f3];
            if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
            if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
            if (f7 == 7'h01 && M_EN) return mNames[f3];
            return "";
         end
         7'h13: begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? "SLLI" : "";
            if (f3 == 3'd5) return (f7 == 7'h00) ? "SRLI" : (f7 == 7'h20) ? "SRAI" : "";
            return iNames[f3];
         end
         7'h03: return ldNames[f3];
         7'h23: return stNames[f3];
         7'h63: return brNames[f3];
         7'h6F: return "JAL";
         7'h37: return "LUI";
         7'h17: return "AUIPC";
         7'h67: return (f3 == 3'd0) ? "JALR" : "";
         default: return "";
      endcase
   endfunction

   function automatic int classBit(input logic [6:0] op);
      case (op)
         7'h33: return 8;
         7'h13: return 7;
         7'h03: return 6;
         7'h23: return 5;
         7'h63: return 4;
         7'h6F: return 3;
         7'h37: return 2;
         7'h17: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] p);
      exp_t        e;
      string       m;
      int          cb;
      logic [31:0] sgn;
      e = '0;
      e.pc = p;
      m = mnemOf(w);
      if (m == "NOP") begin
         e.ch = toChars("NOP");
         return e;
      end
      if (m == "") begin
         e.illegal = 1'b1;
         e.ch = toChars("ILLGL");
         return e;
      end
      cb = classBit(w[6:0]);
      sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
      e.typ = 9'(1) << cb;
      e.ch = toChars(m);
      for (int i = 0; i < 28; i++) if (aluNames[i] == m) e.alu_op = 6'(i);
      if (cb == 6 || cb == 5) e.alu_op = 6'd10;
      for (int i = 1; i < 9; i++) if (brCodes[i] == m) e.branch = 4'(i);
      e.alusrc   = (cb == 7 || cb == 6 || cb == 5 || cb == 1);
      e.memtoreg = (cb == 6);
      e.mem_we   = (cb == 5);
      e.reg_en   = !(cb == 5 || cb == 4);
      if (cb == 6 || cb == 5) e.mem_size = w[14:12];
      if (cb inside {8, 7, 6, 5, 4, 0}) e.rs1 = w[19:15];
      if (cb inside {8, 5, 4}) e.rs2 = w[24:20];
      if (cb inside {8, 7, 6, 3, 2, 1, 0}) e.rd = w[11:7];
      case (cb)
         7, 6, 0: e.imm = (sgn << 12) | 32'(w[31:20]);
         5:       e.imm = (sgn << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
         4:       e.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         3:       e.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         2, 1:    e.imm = w & 32'hFFFF_F000;
         default: e.imm = 32'd0;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [6:0]  ops[9];
      logic [31:0] w;
      int          k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h67};
      w = $urandom;
      k = $urandom_range(0, 19);
      if (k == 0) return 32'd0;
      if (k == 1) return w;
      w[6:0] = ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      e = '0;
      e.ch = "XXXXX";
      if (q.size() != 0) e = q[0];
      checkField({tag, " out_valid"}, 64'(out_valid), 64'(!reset && q.size() != 0));
      checkField({tag, " in_ready"}, 64'(in_ready), 64'(!reset && q.size() < DEPTH));
      checkField({tag, " out_pc"}, 64'(out_pc), 64'(e.pc));
      checkField({tag, " rs1"}, 64'(rs1), 64'(e.rs1));
      checkField({tag, " rs2"}, 64'(rs2), 64'(e.rs2));
      checkField({tag, " rd"}, 64'(rd), 64'(e.rd));
      checkField({tag, " imm"}, 64'(imm), 64'(e.imm));
      checkField({tag, " alu_op"}, 64'(alu_op), 64'(e.alu_op));
      checkField({tag, " branch"}, 64'(branch), 64'(e.branch));
      checkField({tag, " type"}, 64'(instr_type), 64'(e.typ));
      checkField({tag, " alusrc"}, 64'(alusrc), 64'(e.alusrc));
      checkField({tag, " memtoreg"}, 64'(memtoreg), 64'(e.memtoreg));
      checkField({tag, " reg_en"}, 64'(reg_en), 64'(e.reg_en));
      checkField({tag, " mem_we"}, 64'(mem_we), 64'(e.mem_we));
      checkField({tag, " mem_size"}, 64'(mem_size), 64'(e.mem_size));
      checkField({tag, " illegal"}, 64'(illegal), 64'(e.illegal));
      checkField({tag, " char_out"}, 64'(char_out), 64'(e.ch));
   endtask

   task automatic modelUpdate();
      bit canPush;
      bit doPop;
      canPush = !reset && q.size() < DEPTH;
      doPop = !reset && q.size() > 0 && out_ready;
      if (reset || flush) begin
         q.delete();
      end else begin
         if (doPop) void'(q.pop_front());
         if (in_valid && canPush) q.push_back(refDecode(instr, pc));
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      modelUpdate();
      #2;
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input bit v, input logic [31:0] w, input logic [31:0] p,
                                input bit fl, input bit ordy);
      in_valid  = v;
      instr     = w;
      pc        = p;
      flush     = fl;
      out_ready = ordy;
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{32'h0050_0093, "ADDI ", 6'd10, 4'd0, 9'h080, 1'b0, 32'd5,          5'd1};
      vecs[1]  = '{32'hFE00_0EE3, "BEQ  ", 6'd0,  4'd1, 9'h010, 1'b0, 32'hFFFF_FFFC,  5'd0};
      if (M_EN)
         vecs[2] = '{32'h0220_8033, "MUL  ", 6'd20, 4'd0, 9'h100, 1'b0, 32'd0,         5'd0};
      else
         vecs[2] = '{32'h0220_8033, "ILLGL", 6'd0,  4'd0, 9'h000, 1'b1, 32'd0,         5'd0};
      vecs[3]  = '{32'h0000_0000, "NOP  ", 6'd0,  4'd0, 9'h000, 1'b0, 32'd0,          5'd0};
      vecs[4]  = '{32'h4020_81B3, "SUB  ", 6'd1,  4'd0, 9'h100, 1'b0, 32'd0,          5'd3};
      vecs[5]  = '{32'h0040_A103, "LW   ", 6'd10, 4'd0, 9'h040, 1'b0, 32'd4,          5'd2};
      vecs[6]  = '{32'h0000_B003, "ILLGL", 6'd0,  4'd0, 9'h000, 1'b1, 32'd0,          5'd0};
      vecs[7]  = '{32'h0080_00EF, "JAL  ", 6'd0,  4'd7, 9'h008, 1'b0, 32'd8,          5'd1};
      vecs[8]  = '{32'h1234_52B7, "LUI  ", 6'd0,  4'd0, 9'h004, 1'b0, 32'h1234_5000,  5'd5};
      vecs[9]  = '{32'h0000_007F, "ILLGL", 6'd0,  4'd0, 9'h000, 1'b1, 32'd0,          5'd0};
      vecs[10] = '{32'h4030_D093, "SRAI ", 6'd16, 4'd0, 9'h080, 1'b0, 32'h0000_0403,  5'd1};
      vecs[11] = '{32'h0020_A423, "SW   ", 6'd10, 4'd0, 9'h020, 1'b0, 32'd8,          5'd0};

      #1;
      checkField("reset-cycle in_ready", 64'(in_ready), 64'd0);
      checkField("reset-cycle out_valid", 64'(out_valid), 64'd0);
      tick("reset");
      reset = 1'b0;
      #1;
      checkField("post-reset in_ready", 64'(in_ready), 64'd1);
      checkField("post-reset out_valid", 64'(out_valid), 64'd0);
      checkField("post-reset char_out", 64'(char_out), 64'("XXXXX"));

      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].ins, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
         tick("vec push");
         checkField($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
         checkField($sformatf("vec%0d char_out", i), 64'(char_out), 64'(vecs[i].ch));
         checkField($sformatf("vec%0d alu_op", i), 64'(alu_op), 64'(vecs[i].alu));
         checkField($sformatf("vec%0d branch", i), 64'(branch), 64'(vecs[i].br));
         checkField($sformatf("vec%0d type", i), 64'(instr_type), 64'(vecs[i].typ));
         checkField($sformatf("vec%0d illegal", i), 64'(illegal), 64'(vecs[i].ill));
         checkField($sformatf("vec%0d imm", i), 64'(imm), 64'(vecs[i].imm));
         checkField($sformatf("vec%0d rd", i), 64'(rd), 64'(vecs[i].rd));
         checkField($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
         applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
         tick("vec pop");
      end

      // Fill with out_ready low, then drain in order.
      applyStimulus(1'b1, 32'h0010_0093, 32'h200, 1'b0, 1'b0);
      tick("fill1");
      applyStimulus(1'b1, 32'h0020_0093, 32'h204, 1'b0, 1'b0);
      tick("fill2");
      checkField("full in_ready", 64'(in_ready), 64'd0);
      checkField("full head imm", 64'(imm), 64'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      #1;
      checkField("pop-cycle in_ready", 64'(in_ready), 64'd0);
      tick("drain1");
      checkField("after-pop in_ready", 64'(in_ready), 64'd1);
      checkField("drain second imm", 64'(imm), 64'd2);
      tick("drain2");
      checkField("drained out_valid", 64'(out_valid), 64'd0);

      // Flush with a push offered in the same cycle.
      applyStimulus(1'b1, 32'h0030_0093, 32'h300, 1'b0, 1'b0);
      tick("flush fill1");
      applyStimulus(1'b1, 32'h0040_0093, 32'h304, 1'b0, 1'b0);
      tick("flush fill2");
      applyStimulus(1'b1, 32'h0050_0093, 32'h308, 1'b1, 1'b1);
      tick("flush");
      checkField("flush out_valid", 64'(out_valid), 64'd0);
      checkField("flush in_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tick("after flush");
      checkField("flushed word lost", 64'(out_valid), 64'd0);

      // Reset while full with the consumer ready.
      applyStimulus(1'b1, 32'h0060_0093, 32'h400, 1'b0, 1'b0);
      tick("rst fill1");
      applyStimulus(1'b1, 32'h0070_0093, 32'h404, 1'b0, 1'b0);
      tick("rst fill2");
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      checkField("reset no handshake", 64'(out_valid), 64'd0);
      tick("mid reset");
      reset = 1'b0;
      #1;
      checkField("after reset out_valid", 64'(out_valid), 64'd0);
      checkField("after reset char_out", 64'(char_out), 64'("XXXXX"));

      for (int c = 0; c < 600; c++) begin
         applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 49) == 0);
         tick("rand");
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
